// File: rtl/pinmux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pinmux_sel_sequencer
// Purpose  : Holds the pad output-select and peripheral input-select fields
//            that drive the pinmux datapath. Select changes are applied one
//            request at a time. An output-pad change from one driven source
//            to another first parks the pad in high-Z for a settle interval
//            so the pad never switches directly between two drivers.
// Ports    : clk_i           - clock
//            rst_ni          - asynchronous active-low reset
//            req_valid_i     - request present
//            req_ready_o     - block can accept a request (high in IDLE)
//            req_is_in_i     - 0: MIO output select, 1: peripheral input select
//            req_idx_i       - target field index
//            req_sel_i       - new select value
//            done_o          - one-cycle pulse, new value applied
//            err_o           - one-cycle pulse, request rejected
//            busy_o          - high whenever the FSM is not in IDLE
//            mio_out_sel_o   - pad k select at [k*SelW +: SelW]
//            periph_in_sel_o - peripheral k select at [k*SelW +: SelW]
// Revision : 1.0 - initial release
// ============================================================================
module pinmux_sel_sequencer #(
  parameter int NMioPads     = 32,
  parameter int NPeriphIn    = 32,
  parameter int NPeriphOut   = 32,
  parameter int SelW         = 6,
  parameter int SettleCycles = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_is_in_i,
  input  logic [SelW-1:0]            req_idx_i,
  input  logic [SelW-1:0]            req_sel_i,
  output logic                       done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [NMioPads*SelW-1:0]   mio_out_sel_o,
  output logic [NPeriphIn*SelW-1:0]  periph_in_sel_o
);

  localparam int              CNT_W   = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [SelW-1:0] SEL_HIZ = SelW'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PARK   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic [SelW-1:0]  pend_idx;
  logic [SelW-1:0]  pend_sel;

  logic [SelW-1:0]  mio_sel    [NMioPads];
  logic [SelW-1:0]  periph_sel [NPeriphIn];

  // Request decode, evaluated at full width so large parameters cannot alias.
  logic [31:0]     idx32;
  logic [31:0]     sel32;
  logic            out_legal;
  logic            in_legal;
  logic [SelW-1:0] cur_out;
  logic            need_park;

  always_comb begin
    idx32     = 32'(req_idx_i);
    sel32     = 32'(req_sel_i);
    out_legal = (idx32 < NMioPads) && (sel32 <= NPeriphOut + 2);
    in_legal  = (idx32 < NPeriphIn) && (sel32 <= NMioPads + 1);
    cur_out   = SEL_HIZ;
    for (int k = 0; k < NMioPads; k++) begin
      if (idx32 == 32'(k)) cur_out = mio_sel[k];
    end
    // A park is only needed when switching between two different driven
    // sources; moves to or from high-Z, or no-op writes, go straight through.
    need_park = !((cur_out == SEL_HIZ) || (req_sel_i == SEL_HIZ) ||
                  (req_sel_i == cur_out));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      pend_idx <= '0;
      pend_sel <= '0;
      for (int k = 0; k < NMioPads; k++)  mio_sel[k]    <= SEL_HIZ;
      for (int k = 0; k < NPeriphIn; k++) periph_sel[k] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i && ready_q) begin
            if (req_is_in_i) begin
              if (in_legal) begin
                for (int k = 0; k < NPeriphIn; k++) begin
                  if (idx32 == 32'(k)) periph_sel[k] <= req_sel_i;
                end
                done_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end else if (!out_legal) begin
              err_q <= 1'b1;
            end else if (!need_park) begin
              for (int k = 0; k < NMioPads; k++) begin
                if (idx32 == 32'(k)) mio_sel[k] <= req_sel_i;
              end
              done_q <= 1'b1;
            end else begin
              for (int k = 0; k < NMioPads; k++) begin
                if (idx32 == 32'(k)) mio_sel[k] <= SEL_HIZ;
              end
              pend_idx <= req_idx_i;
              pend_sel <= req_sel_i;
              state    <= PARK;
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
        end

        PARK: begin
          if (SettleCycles == 1) begin
            for (int k = 0; k < NMioPads; k++) begin
              if (32'(pend_idx) == 32'(k)) mio_sel[k] <= pend_sel;
            end
            done_q  <= 1'b1;
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt   <= CNT_W'(SettleCycles - 1);
            state <= SETTLE;
          end
        end

        SETTLE: begin
          // The counter reaching zero on this edge is the apply step.
          if (cnt <= CNT_W'(1)) begin
            cnt <= '0;
            for (int k = 0; k < NMioPads; k++) begin
              if (32'(pend_idx) == 32'(k)) mio_sel[k] <= pend_sel;
            end
            done_q  <= 1'b1;
            state   <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  for (genvar k = 0; k < NMioPads; k++) begin : g_mio_pack
    assign mio_out_sel_o[k*SelW +: SelW] = mio_sel[k];
  end

  for (genvar k = 0; k < NPeriphIn; k++) begin : g_periph_pack
    assign periph_in_sel_o[k*SelW +: SelW] = periph_sel[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_pinmux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pinmux_sel_sequencer
// Purpose  : Scoreboard bench for pinmux_sel_sequencer. Stimulus pushes the
//            hand-computed expected response of each accepted request; a
//            monitor pops and compares whenever done/err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pinmux_sel_sequencer;

  localparam int NP  = 32;
  localparam int NI  = 32;
  localparam int NO  = 32;
  localparam int SW  = 6;
  localparam int SC  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_is_in = 1'b0;
  logic [SW-1:0]    req_idx = '0;
  logic [SW-1:0]    req_sel = '0;
  logic             done;
  logic             err;
  logic             busy;
  logic [NP*SW-1:0] mio_sel;
  logic [NI*SW-1:0] per_sel;

  pinmux_sel_sequencer #(
    .NMioPads(NP), .NPeriphIn(NI), .NPeriphOut(NO), .SelW(SW), .SettleCycles(SC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_is_in_i(req_is_in), .req_idx_i(req_idx), .req_sel_i(req_sel),
    .done_o(done), .err_o(err), .busy_o(busy),
    .mio_out_sel_o(mio_sel), .periph_in_sel_o(per_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    bit is_in;
    int idx;
    int val;
    bit chk_field;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  function automatic int get_mio(input int k);
    return int'(mio_sel[k*SW +: SW]);
  endfunction

  function automatic int get_per(input int k);
    return int'(per_sel[k*SW +: SW]);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic chk_reset_fields(input string name);
    logic [NP*SW-1:0] exp_mio;
    logic [NI*SW-1:0] exp_per;
    for (int k = 0; k < NP; k++) exp_mio[k*SW +: SW] = SW'(2);
    exp_per = '0;
    checks++;
    if (mio_sel !== exp_mio || per_sel !== exp_per) begin
      errors++;
      $display("FAIL %s: mio=%h per=%h expected mio=%h per=%h",
               name, mio_sel, per_sel, exp_mio, exp_per);
    end
  endtask

  // Present a request (caller is at a negedge), wait for acceptance and
  // record the expected response. Returns at the negedge after acceptance.
  task automatic issue(input bit is_in, input int idx, input int sel,
                       input bit e, input bit chkf, input int val, input int lat);
    bit   ok;
    exp_t x;
    req_valid = 1'b1;
    req_is_in = is_in;
    req_idx   = SW'(idx);
    req_sel   = SW'(sel);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: idx=%0d sel=%0d never accepted", idx, sel);
    end else begin
      x.is_err    = e;
      x.is_in     = is_in;
      x.idx       = idx;
      x.val       = val;
      x.chk_field = chkf;
      x.cyc       = ncyc + 1 + lat;
      sb.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per done/err pulse.
  initial begin
    exp_t e;
    int   fv;
    forever begin
      @(negedge clk);
      ncyc = ncyc + 1;
      if (rst_n) begin
        if (done && err) begin
          checks++;
          errors++;
          $display("FAIL done_err_overlap: done=%0b err=%0b", done, err);
        end
        if (done || err) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: done=%0b err=%0b at cycle %0d", done, err, ncyc);
          end else begin
            e = sb.pop_front();
            chk("resp_kind_err", int'(err), int'(e.is_err));
            chk("resp_cycle", ncyc, e.cyc);
            if (e.chk_field) begin
              fv = e.is_in ? get_per(e.idx) : get_mio(e.idx);
              chk(e.is_in ? "periph_field" : "mio_field", fv, e.val);
            end
          end
        end else if (sb.size() > 0 && sb[0].cyc < ncyc) begin
          checks++;
          errors++;
          $display("FAIL missing_resp: expected at cycle %0d, none by %0d", sb[0].cyc, ncyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_fields("reset_fields");
    chk("reset_ready", int'(req_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done_err", int'({done, err}), 0);

    // Output from high-Z: direct apply
    issue(1'b0, 5, 10, 1'b0, 1'b1, 10, 0);

    // Parked change 10 -> 3; a second request is held valid during the park
    issue(1'b0, 5, 3, 1'b0, 1'b1, 3, SC);
    req_valid = 1'b1; req_is_in = 1'b1; req_idx = SW'(31); req_sel = SW'(33);
    for (int i = 0; i < SC; i++) begin
      chk("park_field_hiz", get_mio(5), 2);
      chk("park_ready_low", int'(req_ready), 0);
      chk("park_busy", int'(busy), 1);
      @(negedge clk);
    end
    chk("park_held_not_taken", get_per(31), 0);
    chk("post_park_ready", int'(req_ready), 1);
    issue(1'b1, 31, 33, 1'b0, 1'b1, 33, 0);

    // Input boundary: sel 34 > NMioPads+1 is illegal
    issue(1'b1, 0, 34, 1'b1, 1'b1, 0, 0);
    // Illegal output index, then output sel boundary 35 illegal / 34 legal
    issue(1'b0, 32, 3, 1'b1, 1'b0, 0, 0);
    chk("err_ready_high", int'(req_ready), 1);
    issue(1'b0, 1, 35, 1'b1, 1'b1, 2, 0);
    issue(1'b0, 1, 34, 1'b0, 1'b1, 34, 0);

    // Back-to-back legal input requests
    issue(1'b1, 0, 1, 1'b0, 1'b1, 1, 0);
    issue(1'b1, 1, 2, 1'b0, 1'b1, 2, 0);
    issue(1'b1, 2, 33, 1'b0, 1'b1, 33, 0);

    // No-park output cases: same value, to high-Z, from high-Z
    issue(1'b0, 5, 3, 1'b0, 1'b1, 3, 0);
    issue(1'b0, 5, 2, 1'b0, 1'b1, 2, 0);
    issue(1'b0, 5, 3, 1'b0, 1'b1, 3, 0);
    // Parked change 34 -> 0 on pad 1
    issue(1'b0, 1, 0, 1'b0, 1'b1, 0, SC);
    idle_req();
    repeat (SC + 1) @(negedge clk);
    chk("pad1_final", get_mio(1), 0);
    chk("pad5_untouched", get_mio(5), 3);

    // Reset during SETTLE of a 5 -> 7 change on pad 2
    issue(1'b0, 2, 5, 1'b0, 1'b1, 5, 0);
    issue(1'b0, 2, 7, 1'b0, 1'b1, 7, SC);
    idle_req();
    repeat (2) @(negedge clk);
    chk("mid_busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk_reset_fields("midreset_fields");
    chk("midreset_ready", int'(req_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SC + 4) @(negedge clk);
    chk("post_reset_pad2_hiz", get_mio(2), 2);
    chk("post_reset_ready", int'(req_ready), 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
